mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline.
- Turns the EX-stage effective address, store data and funct3 into a valid/ack transaction on the data-memory bus.
- Stalls the pipeline while the transaction is outstanding.
- Returns load data aligned and sign/zero-extended as memory_data, which the writeback stage selects against alu_data.

Parameters:
WORD_SIZE, 32, datapath and bus data width (only 32 supported)
TIMEOUT_CYCLES, 16, max cycles in BUSY waiting for dmem_ack before abort (range 1..255)

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
alu_data  input  WORD_SIZE  effective byte address from EX/MEM register
store_data  input  WORD_SIZE  rs2 value for stores
funct3  input  3  RV32I load/store width code
mem_read  input  1  current instruction is a load
mem_write  input  1  current instruction is a store
dmem_req  output  1  bus request valid
dmem_we  output  1  1 = write, 0 = read
dmem_addr  output  WORD_SIZE  word-aligned address ({alu_data[31:2],2'b00})
dmem_wdata  output  WORD_SIZE  lane-replicated store data
dmem_be  output  4  byte enables
dmem_rdata  input  WORD_SIZE  read data, valid when dmem_ack=1
dmem_ack  input  1  one-cycle completion strobe from memory
memory_data  output  WORD_SIZE  formatted load result to writeback
mem_stall  output  1  hold IF..EX/MEM pipeline registers
misaligned  output  1  combinational: current access is misaligned
bus_timeout  output  1  one-cycle pulse: transaction aborted

Behaviour:
- Clocking and reset: one clock domain, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, timeout counter=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, memory_data=0, bus_timeout=0.
- Reset mid-transaction: dmem_req drops immediately (asynchronously). The memory side must tolerate an abandoned request.
- access = mem_read | mem_write. If both are set, treat as a store.
- Misalignment rules:
  - Halfword (funct3[1:0]=01) with alu_data[0]=1 is misaligned.
  - Word (funct3[1:0]=10) with alu_data[1:0]!=0 is misaligned.
  - Byte accesses are never misaligned.
  - Reserved funct3 (011, 110, 111) is handled as a word access.
- misaligned = access & rule hit, evaluated in IDLE only. A misaligned access issues no bus request, does not stall, and leaves memory_data unchanged.
- FSM states IDLE, BUSY, DONE:
  - IDLE: if access & !misaligned, register dmem_req=1, addr, we, be, wdata; counter=0; go to BUSY. Otherwise stay.
  - BUSY: hold all dmem_* outputs stable and increment counter.
    - If dmem_ack=1: drop dmem_req. For loads, register the formatted dmem_rdata into memory_data (stores leave it unchanged). Go to DONE.
    - Else if counter == TIMEOUT_CYCLES-1: drop dmem_req, set memory_data=0, pulse bus_timeout, go to DONE.
  - DONE: one cycle, stall released so the pipeline advances; unconditionally return to IDLE.
- mem_stall = (IDLE & access & !misaligned) | BUSY. Combinational, so the instruction is held from its first MEM cycle.
- Latency: minimum 3 cycles (IDLE, BUSY with ack, DONE). Each extra wait cycle adds 1.
- dmem_ack arriving in IDLE or DONE is ignored.
- Store formatting:
  - Byte: be = 4'b0001 << addr[1:0]; wdata = byte replicated x4.
  - Half: be = 4'b0011 << addr[1:0]; wdata = halfword replicated x2.
  - Word: be = 4'b1111.
  - Loads drive be = 4'b1111, dmem_we=0.
- Load formatting (little-endian): lane selected by addr[1:0] captured at request time.
  - 000 LB: sign-extend selected byte.
  - 100 LBU: zero-extend selected byte.
  - 001 LH: sign-extend halfword at addr[1].
  - 101 LHU: zero-extend halfword at addr[1].
  - 010 and reserved: full word.
- Back-to-back accesses: the next access starts in the IDLE cycle immediately after DONE. The minimum spacing is 3 cycles per access.

Test Plan:
- Reset then LW: rst_n low while BUSY -> dmem_req=0 immediately and memory_data=0. Release, then LW alu_data=0x100, ack after 2 wait cycles -> dmem_addr=0x100, be=1111, mem_stall high 4 cycles, memory_data=dmem_rdata in DONE.
- LB/LBU lanes: dmem_rdata=0x80FF7F01 at alu_data=0x203 -> LB=0xFFFFFF80, LBU=0x00000080. At 0x201, LB=0x0000007F.
- LH/LHU: rdata=0x8001ABCD. LH @0x2 -> 0xFFFF8001; LHU @0x0 -> 0x0000ABCD.
- SB store_data=0x000000A5 @0x1 -> be=0010, wdata=0xA5A5A5A5, we=1. SH @0x2 -> be=1100. SW @0x0 -> be=1111.
- Misaligned LW @0x102 -> misaligned=1, dmem_req never asserts, mem_stall=0, memory_data unchanged. SH @0x3 -> same behaviour.
- Timeout with TIMEOUT_CYCLES=4 and ack never asserted -> dmem_req drops after 4 BUSY cycles, bus_timeout=1 for exactly 1 cycle, memory_data=0. A late ack in IDLE has no effect.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: turns EX/MEM address, store data and funct3 into a req/ack
// data-memory transaction, stalls while it is outstanding and formats load results.
module mem_stage #(
   parameter int WORD_SIZE      = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WORD_SIZE-1:0] alu_data,
   input  logic [WORD_SIZE-1:0] store_data,
   input  logic [2:0]           funct3,
   input  logic                 mem_read,
   input  logic                 mem_write,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [WORD_SIZE-1:0] dmem_addr,
   output logic [WORD_SIZE-1:0] dmem_wdata,
   output logic [3:0]           dmem_be,
   input  logic [WORD_SIZE-1:0] dmem_rdata,
   input  logic                 dmem_ack,
   output logic [WORD_SIZE-1:0] memory_data,
   output logic                 mem_stall,
   output logic                 misaligned,
   output logic                 bus_timeout
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

   state_t         state_reg, state_next;
   logic [7:0]     count_reg;
   logic [1:0]     lane_reg;
   logic [2:0]     fmt_reg;
   logic           load_reg;

   logic           access;
   logic           width_byte;
   logic           width_half;
   logic           rule_hit;
   logic           issue;
   logic [3:0]     be_next;
   logic [WORD_SIZE-1:0] wdata_next;
   logic [WORD_SIZE-1:0] load_fmt;
   logic [7:0]     rd_byte [4];
   logic [7:0]     sel_byte;
   logic [15:0]    sel_half;

   // Reserved widths (funct3[1:0]=11) fall through to word handling.
   assign access     = mem_read | mem_write;
   assign width_byte = (funct3[1:0] == 2'b00);
   assign width_half = (funct3[1:0] == 2'b01);
   assign rule_hit   = width_half ? alu_data[0]
                                  : (!width_byte && (alu_data[1:0] != 2'b00));
   assign misaligned = (state_reg == IDLE) & access & rule_hit;
   assign issue      = (state_reg == IDLE) & access & !rule_hit;
   assign mem_stall  = issue | (state_reg == BUSY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (issue) state_next = BUSY;
         BUSY:    if (dmem_ack || (count_reg == LAST_COUNT)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Store lane placement; loads always read the full word.
   always_comb begin
      be_next    = 4'b1111;
      wdata_next = store_data;
      if (width_byte) begin
         wdata_next = {4{store_data[7:0]}};
      end else if (width_half) begin
         wdata_next = {2{store_data[15:0]}};
      end
      if (mem_write) begin
         if (width_byte) begin
            be_next = 4'b0001 << alu_data[1:0];
         end else if (width_half) begin
            be_next = 4'b0011 << alu_data[1:0];
         end
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = dmem_rdata[8*gi +: 8];
   end

   assign sel_byte = rd_byte[lane_reg];
   assign sel_half = lane_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

   always_comb begin
      load_fmt = dmem_rdata;
      case (fmt_reg)
         3'b000:  load_fmt = {{24{sel_byte[7]}}, sel_byte};
         3'b100:  load_fmt = {24'd0, sel_byte};
         3'b001:  load_fmt = {{16{sel_half[15]}}, sel_half};
         3'b101:  load_fmt = {16'd0, sel_half};
         default: load_fmt = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg   <= 8'd0;
         lane_reg    <= 2'b00;
         fmt_reg     <= 3'b000;
         load_reg    <= 1'b0;
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         dmem_addr   <= '0;
         dmem_wdata  <= '0;
         dmem_be     <= 4'b0000;
         memory_data <= '0;
         bus_timeout <= 1'b0;
      end else begin
         bus_timeout <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (issue) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_write;
                  dmem_addr  <= {alu_data[WORD_SIZE-1:2], 2'b00};
                  dmem_be    <= be_next;
                  dmem_wdata <= wdata_next;
                  lane_reg   <= alu_data[1:0];
                  fmt_reg    <= funct3;
                  load_reg   <= !mem_write;
                  count_reg  <= 8'd0;
               end
            end
            BUSY: begin
               count_reg <= count_reg + 8'd1;
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  if (load_reg) memory_data <= load_fmt;
               end else if (count_reg == LAST_COUNT) begin
                  dmem_req    <= 1'b0;
                  memory_data <= '0;
                  bus_timeout <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
